// File: rtl/uart_tx_fifo_if.sv
// Byte-stream valid/ready handshake feeding the UART transmit FIFO.
// A push happens on any clock edge where in_valid and in_ready are both high.
interface uart_tx_fifo_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: DEPTH-entry byte FIFO feeding a start/data/parity/stop serialiser.
// A byte pushed into an empty idle enabled block starts its start bit one edge later; in_ready drops only when full.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 4,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                     txclk,
  input  logic                     reset,
  input  logic                     tx_enable,
  uart_tx_fifo_if.slave            in_if,
  output logic                     tx_out,
  output logic                     tx_busy,
  output logic                     tx_empty,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic          PAR_EN    = (PARITY_EN != 0);
  localparam logic          PAR_ODD   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic            tx_q, tx_d;

  logic            push, pop;
  logic            bit_end, last_stop, frame_avail;
  logic [7:0]      head;

  assign in_if.in_ready = (count_q != FULL);
  assign push           = in_if.in_valid && in_if.in_ready;
  assign head           = mem_q[rd_ptr_q];

  assign bit_end     = (baud_q == BAUD_LAST);
  assign last_stop   = (bit_idx_q == STOP_LAST);
  assign frame_avail = tx_enable && (count_q != '0);
  // A pop only ever happens when a frame is about to start, from IDLE or at the end of the last stop bit.
  assign pop = frame_avail &&
               ((state_q == S_IDLE) ||
                ((state_q == S_STOP) && bit_end && last_stop));

  assign tx_out     = tx_q;
  assign tx_busy    = (state_q != S_IDLE);
  assign tx_empty   = (count_q == '0) && (state_q == S_IDLE);
  assign fifo_count = count_q;

  always_ff @(posedge txclk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (pop) state_d = S_START;
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end && bit_idx_q == 3'd7) state_d = PAR_EN ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end && last_stop) state_d = pop ? S_START : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    baud_d    = bit_end ? '0 : baud_q + BW'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    tx_d      = tx_q;
    unique case (state_q)
      S_IDLE: begin
        baud_d    = '0;
        bit_idx_d = '0;
        tx_d      = 1'b1;
        if (pop) begin
          shift_d  = head;
          parity_d = (^head) ^ PAR_ODD;
          tx_d     = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            tx_d      = PAR_EN ? parity_q : 1'b1;
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          tx_d      = 1'b1;
          bit_idx_d = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (last_stop) begin
            bit_idx_d = '0;
            tx_d      = 1'b1;
            if (pop) begin
              shift_d  = head;
              parity_d = (^head) ^ PAR_ODD;
              tx_d     = 1'b0;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      default: begin
        baud_d    = '0;
        bit_idx_d = '0;
        tx_d      = 1'b1;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge txclk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge txclk) begin
    if (push) mem_q[wr_ptr_q] <= in_if.in_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four instances cover the base frame, even/odd parity and two stop bits.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int hi_run;

  uart_tx_fifo_if ifa ();
  uart_tx_fifo_if ifb ();
  uart_tx_fifo_if ifc ();
  uart_tx_fifo_if ifd ();

  logic       en_a, en_b, en_c, en_d;
  logic       tx_a, tx_b, tx_c, tx_d;
  logic       busy_a, busy_b, busy_c, busy_d;
  logic       empty_a, empty_b, empty_c, empty_d;
  logic [2:0] cnt_a, cnt_b, cnt_c, cnt_d;

  logic [7:0] q2 [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
  logic [7:0] q4 [3] = '{8'h81, 8'h42, 8'h24};
  logic [7:0] q6 [3] = '{8'h12, 8'h34, 8'h56};

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DEPTH(4)) dut_a (
    .txclk(clk), .reset(rst), .tx_enable(en_a), .in_if(ifa.slave),
    .tx_out(tx_a), .tx_busy(busy_a), .tx_empty(empty_a), .fifo_count(cnt_a));

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DEPTH(4), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
    .txclk(clk), .reset(rst), .tx_enable(en_b), .in_if(ifb.slave),
    .tx_out(tx_b), .tx_busy(busy_b), .tx_empty(empty_b), .fifo_count(cnt_b));

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DEPTH(4), .PARITY_EN(1), .PARITY_ODD(1)) dut_c (
    .txclk(clk), .reset(rst), .tx_enable(en_c), .in_if(ifc.slave),
    .tx_out(tx_c), .tx_busy(busy_c), .tx_empty(empty_c), .fifo_count(cnt_c));

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DEPTH(4), .STOP_BITS(2)) dut_d (
    .txclk(clk), .reset(rst), .tx_enable(en_d), .in_if(ifd.slave),
    .tx_out(tx_d), .tx_busy(busy_d), .tx_empty(empty_d), .fifo_count(cnt_d));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level at cycle c of a frame with 4 clocks per bit.
  function automatic logic exp_bit(input logic [7:0] d, input int pen, input int podd, input int c);
    int b;
    b = c / 4;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (pen != 0 && b == 9) return (^d) ^ (podd != 0);
    return 1'b1;
  endfunction

  initial begin
    rst = 1'b1;
    {en_a, en_b, en_c, en_d} = 4'b0;
    ifa.in_valid = 1'b0; ifa.in_data = 8'h00;
    ifb.in_valid = 1'b0; ifb.in_data = 8'h00;
    ifc.in_valid = 1'b0; ifc.in_data = 8'h00;
    ifd.in_valid = 1'b0; ifd.in_data = 8'h00;
    #2;
    chk("rst_tx_out", tx_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_empty", empty_a, 1);
    chk("rst_count", cnt_a, 0);
    chk("rst_ready", ifa.in_ready, 1);
    tick();
    rst = 1'b0;
    tick();

    // Single byte 0xA5 into an idle enabled block
    en_a = 1'b1;
    ifa.in_valid = 1'b1; ifa.in_data = 8'hA5;
    tick();
    ifa.in_valid = 1'b0;
    chk("t1_count_after_push", cnt_a, 1);
    chk("t1_line_still_idle", tx_a, 1);
    tick();
    for (int c = 0; c < 40; c++) begin
      chk($sformatf("t1_line_c%0d", c), tx_a, exp_bit(8'hA5, 0, 0, c));
      if (c == 0) chk("t1_busy", busy_a, 1);
      tick();
    end
    chk("t1_busy_end", busy_a, 0);
    chk("t1_empty_end", empty_a, 1);

    // Fill while disabled, then drain five frames back to back
    en_a = 1'b0;
    ifa.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ifa.in_data = q2[i];
      tick();
    end
    chk("t2_count_full", cnt_a, 4);
    chk("t2_ready_full", ifa.in_ready, 0);
    ifa.in_data = q2[4];
    tick();
    tick();
    chk("t2_count_held", cnt_a, 4);
    chk("t2_ready_held", ifa.in_ready, 0);
    chk("t2_idle_line", tx_a, 1);
    en_a = 1'b1;
    tick();
    for (int c = 0; c < 200; c++) begin
      if (c == 0) chk("t2_ready_after_pop", ifa.in_ready, 1);
      if (c == 1) begin
        chk("t2_count_refill", cnt_a, 4);
        ifa.in_valid = 1'b0;
      end
      chk($sformatf("t2_line_c%0d", c), tx_a, exp_bit(q2[c/40], 0, 0, c % 40));
      tick();
    end
    chk("t2_busy_end", busy_a, 0);
    chk("t2_empty_end", empty_a, 1);
    chk("t2_count_end", cnt_a, 0);

    // Drop enable mid-frame with two bytes still queued
    en_a = 1'b0;
    ifa.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ifa.in_data = q4[i];
      tick();
    end
    ifa.in_valid = 1'b0;
    chk("t4_count_queued", cnt_a, 3);
    en_a = 1'b1;
    tick();
    for (int c = 0; c < 40; c++) begin
      if (c == 10) en_a = 1'b0;
      chk($sformatf("t4_line_c%0d", c), tx_a, exp_bit(q4[0], 0, 0, c));
      tick();
    end
    for (int c = 0; c < 20; c++) begin
      chk($sformatf("t4_hold_line_c%0d", c), tx_a, 1);
      chk($sformatf("t4_hold_count_c%0d", c), cnt_a, 2);
      tick();
    end
    chk("t4_hold_busy", busy_a, 0);
    en_a = 1'b1;
    tick();
    chk("t4_restart_line", tx_a, 0);
    chk("t4_restart_count", cnt_a, 1);

    // Reset at cycle 17 of the 0x42 frame
    for (int c = 0; c < 17; c++) tick();
    chk("t5_line_before_reset", tx_a, 0);
    rst = 1'b1;
    #1;
    chk("t5_rst_line", tx_a, 1);
    chk("t5_rst_count", cnt_a, 0);
    chk("t5_rst_ready", ifa.in_ready, 1);
    chk("t5_rst_busy", busy_a, 0);
    chk("t5_rst_empty", empty_a, 1);
    rst = 1'b0;
    tick();
    ifa.in_valid = 1'b1; ifa.in_data = 8'h3C;
    tick();
    ifa.in_valid = 1'b0;
    tick();
    for (int c = 0; c < 40; c++) begin
      chk($sformatf("t5_line_c%0d", c), tx_a, exp_bit(8'h3C, 0, 0, c));
      tick();
    end
    chk("t5_empty_end", empty_a, 1);
    chk("t5_count_end", cnt_a, 0);

    // 0x07 with even parity (bit 1) and odd parity (bit 0), 44-cycle frames
    en_b = 1'b1; en_c = 1'b1;
    ifb.in_valid = 1'b1; ifb.in_data = 8'h07;
    ifc.in_valid = 1'b1; ifc.in_data = 8'h07;
    tick();
    ifb.in_valid = 1'b0;
    ifc.in_valid = 1'b0;
    tick();
    for (int c = 0; c < 44; c++) begin
      chk($sformatf("t3_even_c%0d", c), tx_b, exp_bit(8'h07, 1, 0, c));
      chk($sformatf("t3_odd_c%0d", c), tx_c, exp_bit(8'h07, 1, 1, c));
      if (c == 36) begin
        chk("t3_parity_even", tx_b, 1);
        chk("t3_parity_odd", tx_c, 0);
      end
      if (c == 43) chk("t3_busy_last_cycle", busy_b, 1);
      tick();
    end
    chk("t3_even_done", busy_b, 0);
    chk("t3_odd_done", busy_c, 0);

    // Two stop bits: 8-cycle high gap, push and pop on the same edge
    ifd.in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ifd.in_data = q6[i];
      tick();
    end
    ifd.in_valid = 1'b0;
    chk("t6_count_queued", cnt_d, 2);
    en_d = 1'b1;
    tick();
    hi_run = 0;
    for (int c = 0; c < 132; c++) begin
      if (c == 43) begin
        chk("t6_count_before_swap", cnt_d, 1);
        ifd.in_valid = 1'b1; ifd.in_data = q6[2];
      end
      if (c == 44) begin
        chk("t6_count_push_pop", cnt_d, 1);
        chk("t6_gap_len", hi_run, 8);
        ifd.in_valid = 1'b0;
      end
      chk($sformatf("t6_line_c%0d", c), tx_d, exp_bit(q6[c/44], 0, 0, c % 44));
      hi_run = (tx_d === 1'b1) ? hi_run + 1 : 0;
      tick();
    end
    chk("t6_busy_end", busy_d, 0);
    chk("t6_empty_end", empty_d, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
